conv_addr_seq: RTL and testbench

Address and control sequencer for the convolution core's datapath, directly upstream of the accumulating adder register. For each output sample it issues X/Y memory read addresses, pulses the accumulator clear and enable strobes, and writes the finished sum to Z memory. Computes Z[n] = Σ X[k]·Y[n−k] for n = 0 … sizeX+sizeY−2. X/Y memories have 1-cycle synchronous read; the multiplier between memory and accumulator is combinational.

---
 rtl/conv_addr_seq.sv | 161 ++++++++++++++++
 tb/tb_conv_addr_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_addr_seq.sv
// conv_addr_seq: address and strobe sequencer for the convolution core.
// For every output sample n it clears the accumulator, walks the valid k
// range issuing X[k] / Y[n-k] reads, lets the last product settle into the
// accumulator, then writes the sum to Z[n].
module conv_addr_seq #(
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH:0]   sizeX_i,
   input  logic [ADDR_WIDTH:0]   sizeY_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  memX_rd_o,
   output logic [ADDR_WIDTH-1:0] memX_addr_o,
   output logic                  memY_rd_o,
   output logic [ADDR_WIDTH-1:0] memY_addr_o,
   output logic                  acc_clr_o,
   output logic                  acc_en_o,
   output logic                  memZ_wr_o,
   output logic [ADDR_WIDTH:0]   memZ_addr_o
);

   localparam int AW = ADDR_WIDTH;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CLEAR = 3'd1;
   localparam logic [2:0] READ  = 3'd2;
   localparam logic [2:0] DRAIN = 3'd3;
   localparam logic [2:0] WRITE = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   logic [2:0]    state_q, state_nxt;
   logic [AW:0]   size_x_q, size_x_nxt;
   logic [AW:0]   size_y_q, size_y_nxt;
   logic [AW:0]   n_q, n_nxt;
   logic [AW-1:0] k_q, k_nxt;
   logic [AW-1:0] k_hi_q, k_hi_nxt;

   // k range bounds for the current n and the final-sample test
   logic          k_lo_pos;
   logic [AW-1:0] k_lo;
   logic [AW:0]   x_last;
   logic [AW-1:0] k_hi;
   logic          n_is_last;
   logic [AW-1:0] y_addr_nxt;

   // Range bounds: n-sizeY+1 is evaluated as a compare in AW+2 bits so a
   // negative lower bound clamps to 0 instead of wrapping.
   always_comb begin
      k_lo_pos  = ({1'b0, n_q} + (AW+2)'(1)) > {1'b0, size_y_q};
      k_lo      = k_lo_pos ? AW'(n_q - size_y_q + (AW+1)'(1)) : '0;
      x_last    = size_x_q - (AW+1)'(1);
      k_hi      = AW'((n_q < x_last) ? n_q : x_last);
      n_is_last = ({1'b0, n_q} ==
                   ({1'b0, size_x_q} + {1'b0, size_y_q} - (AW+2)'(2)));
   end

   // Next-state and counter logic for the sequencer FSM
   always_comb begin
      state_nxt  = state_q;
      size_x_nxt = size_x_q;
      size_y_nxt = size_y_q;
      n_nxt      = n_q;
      k_nxt      = k_q;
      k_hi_nxt   = k_hi_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               size_x_nxt = sizeX_i;
               size_y_nxt = sizeY_i;
               n_nxt      = '0;
               if ((sizeX_i == '0) || (sizeY_i == '0)) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = CLEAR;
               end
            end
         end
         CLEAR: begin
            k_nxt     = k_lo;
            k_hi_nxt  = k_hi;
            state_nxt = READ;
         end
         READ: begin
            if (k_q == k_hi_q) begin
               state_nxt = DRAIN;
            end else begin
               k_nxt = k_q + AW'(1);
            end
         end
         DRAIN: begin
            state_nxt = WRITE;
         end
         WRITE: begin
            if (n_is_last) begin
               state_nxt = DONE;
            end else begin
               n_nxt     = n_q + (AW+1)'(1);
               state_nxt = CLEAR;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      y_addr_nxt = AW'(n_nxt - {1'b0, k_nxt});
   end

   // FSM state, latched sizes and loop counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         size_x_q <= '0;
         size_y_q <= '0;
         n_q      <= '0;
         k_q      <= '0;
         k_hi_q   <= '0;
      end else begin
         state_q  <= state_nxt;
         size_x_q <= size_x_nxt;
         size_y_q <= size_y_nxt;
         n_q      <= n_nxt;
         k_q      <= k_nxt;
         k_hi_q   <= k_hi_nxt;
      end
   end

   // Registered outputs: decoded from the state being entered so each strobe
   // lines up with its state; acc_en is the READ strobe delayed one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         memX_rd_o   <= 1'b0;
         memX_addr_o <= '0;
         memY_rd_o   <= 1'b0;
         memY_addr_o <= '0;
         acc_clr_o   <= 1'b0;
         acc_en_o    <= 1'b0;
         memZ_wr_o   <= 1'b0;
         memZ_addr_o <= '0;
      end else begin
         busy_o      <= (state_nxt != IDLE);
         done_o      <= (state_nxt == DONE);
         memX_rd_o   <= (state_nxt == READ);
         memX_addr_o <= (state_nxt == READ) ? k_nxt : '0;
         memY_rd_o   <= (state_nxt == READ);
         memY_addr_o <= (state_nxt == READ) ? y_addr_nxt : '0;
         acc_clr_o   <= (state_nxt == CLEAR);
         acc_en_o    <= (state_q == READ);
         memZ_wr_o   <= (state_nxt == WRITE);
         memZ_addr_o <= (state_nxt == WRITE) ? n_nxt : '0;
      end
   end

endmodule

// File: tb/tb_conv_addr_seq.sv
// Bench for conv_addr_seq: per-cycle output trace against a reference
// schedule built from the convolution index sets, plus an X/Y memory,
// multiplier and accumulator model that yields the Z values.
module tb_conv_addr_seq;

   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic [AW:0]   sizeX_i;
   logic [AW:0]   sizeY_i;
   logic          busy_o;
   logic          done_o;
   logic          memX_rd_o;
   logic [AW-1:0] memX_addr_o;
   logic          memY_rd_o;
   logic [AW-1:0] memY_addr_o;
   logic          acc_clr_o;
   logic          acc_en_o;
   logic          memZ_wr_o;
   logic [AW:0]   memZ_addr_o;

   conv_addr_seq #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start_i(start_i),
      .sizeX_i(sizeX_i), .sizeY_i(sizeY_i),
      .busy_o(busy_o), .done_o(done_o),
      .memX_rd_o(memX_rd_o), .memX_addr_o(memX_addr_o),
      .memY_rd_o(memY_rd_o), .memY_addr_o(memY_addr_o),
      .acc_clr_o(acc_clr_o), .acc_en_o(acc_en_o),
      .memZ_wr_o(memZ_wr_o), .memZ_addr_o(memZ_addr_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          busy;
      logic          done;
      logic          xrd;
      logic [AW-1:0] xa;
      logic          yrd;
      logic [AW-1:0] ya;
      logic          clr;
      logic          en;
      logic          zwr;
      logic [AW:0]   za;
   } obs_t;

   obs_t obs;
   assign obs = {busy_o, done_o, memX_rd_o, memX_addr_o, memY_rd_o, memY_addr_o,
                 acc_clr_o, acc_en_o, memZ_wr_o, memZ_addr_o};

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   xmem[32];
   int   ymem[32];
   int   xd, yd, acc;
   int   z_got[64];

   // Datapath model: 1-cycle synchronous memories, combinational multiply,
   // accumulating register with clear and enable.
   always @(posedge clk) begin
      if (memX_rd_o) xd <= xmem[memX_addr_o];
      if (memY_rd_o) yd <= ymem[memY_addr_o];
      if (acc_clr_o) acc <= 0;
      else if (acc_en_o) acc <= acc + xd * yd;
   end

   // Reference schedule: one CLEAR, one READ per valid (k, n-k) pair,
   // DRAIN, WRITE per output sample, then DONE; enable is reads shifted by one.
   task automatic build_exp(input int sx, input int sy);
      obs_t e;
      exp_q.delete();
      if (sx == 0 || sy == 0) begin
         e = '0; e.busy = 1'b1; e.done = 1'b1;
         exp_q.push_back(e);
         return;
      end
      for (int n = 0; n <= sx + sy - 2; n++) begin
         e = '0; e.busy = 1'b1; e.clr = 1'b1;
         exp_q.push_back(e);
         for (int k = 0; k < sx; k++) begin
            if (n - k >= 0 && n - k < sy) begin
               e = '0; e.busy = 1'b1;
               e.xrd = 1'b1; e.xa = AW'(k);
               e.yrd = 1'b1; e.ya = AW'(n - k);
               exp_q.push_back(e);
            end
         end
         e = '0; e.busy = 1'b1;
         exp_q.push_back(e);
         e = '0; e.busy = 1'b1; e.zwr = 1'b1; e.za = (AW+1)'(n);
         exp_q.push_back(e);
      end
      e = '0; e.busy = 1'b1; e.done = 1'b1;
      exp_q.push_back(e);
      for (int i = exp_q.size() - 1; i > 0; i--) begin
         e = exp_q[i];
         e.en = exp_q[i-1].xrd;
         exp_q[i] = e;
      end
   endtask

   task automatic fill_random(input int maxv);
      for (int i = 0; i < 32; i++) begin
         xmem[i] = int'($urandom_range(0, maxv));
         ymem[i] = int'($urandom_range(0, maxv));
      end
   endtask

   // Runs one start; disturb toggles start/sizes while busy; abort_at >= 0
   // asserts reset mid-cycle at that trace index.
   task automatic run_seq(input string name, input int sx, input int sy,
                          input bit disturb, input int abort_at);
      int busy_cnt = 0;
      int zw       = 0;
      int zexp[64];
      int exp_cycles;
      build_exp(sx, sy);
      for (int i = 0; i < 64; i++) begin
         zexp[i]  = 0;
         z_got[i] = -1;
      end
      @(negedge clk);
      n_checks++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL %s idle: got %h expected %h", name, obs, obs_t'('0));
      end
      start_i = 1'b1;
      sizeX_i = (AW+1)'(sx);
      sizeY_i = (AW+1)'(sy);
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         start_i = disturb ? 1'($urandom_range(0, 1)) : 1'b0;
         if (disturb) begin
            sizeX_i = (AW+1)'($urandom_range(0, 32));
            sizeY_i = (AW+1)'($urandom_range(0, 32));
         end
         n_checks++;
         if (obs !== exp_q[i]) begin
            n_fail++;
            $display("FAIL %s trace cycle %0d: got %h expected %h", name, i, obs, exp_q[i]);
         end
         if (busy_o === 1'b1) busy_cnt++;
         if (memZ_wr_o === 1'b1) begin
            zw++;
            z_got[memZ_addr_o] = acc;
         end
         if (i == abort_at) begin
            rst = 1'b1;
            #1;
            n_checks++;
            if (obs !== '0) begin
               n_fail++;
               $display("FAIL %s async reset: got %h expected 0", name, obs);
            end
            @(negedge clk);
            start_i = 1'b0;
            n_checks++;
            if (obs !== '0) begin
               n_fail++;
               $display("FAIL %s held reset: got %h expected 0", name, obs);
            end
            rst = 1'b0;
            @(negedge clk);
            n_checks++;
            if (obs !== '0) begin
               n_fail++;
               $display("FAIL %s after reset (no done): got %h expected 0", name, obs);
            end
            return;
         end
      end
      start_i = 1'b0;
      exp_cycles = (sx == 0 || sy == 0) ? 1 : sx * sy + 3 * (sx + sy - 1) + 1;
      n_checks++;
      if (busy_cnt != exp_cycles) begin
         n_fail++;
         $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_cnt, exp_cycles);
      end
      n_checks++;
      if (zw != ((sx == 0 || sy == 0) ? 0 : sx + sy - 1)) begin
         n_fail++;
         $display("FAIL %s Z writes: got %0d expected %0d", name, zw,
                  (sx == 0 || sy == 0) ? 0 : sx + sy - 1);
      end
      if (sx > 0 && sy > 0) begin
         for (int i = 0; i < sx; i++)
            for (int j = 0; j < sy; j++)
               zexp[i+j] += xmem[i] * ymem[j];
         for (int n = 0; n <= sx + sy - 2; n++) begin
            n_checks++;
            if (z_got[n] != zexp[n]) begin
               n_fail++;
               $display("FAIL %s Z[%0d]: got %0d expected %0d", name, n, z_got[n], zexp[n]);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start_i = 1'b0; sizeX_i = '0; sizeY_i = '0;
      #12;
      n_checks++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL reset state: got %h expected 0", obs);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int zref[4];
      fill_random(15);
      run_seq("basic_1x1", 1, 1, 1'b0, -1);
      xmem[0] = 1; xmem[1] = 2; xmem[2] = 3;
      ymem[0] = 1; ymem[1] = 1;
      run_seq("basic_3x2", 3, 2, 1'b0, -1);
      zref[0] = 1; zref[1] = 3; zref[2] = 5; zref[3] = 3;
      for (int n = 0; n < 4; n++) begin
         n_checks++;
         if (z_got[n] != zref[n]) begin
            n_fail++;
            $display("FAIL basic_3x2 literal Z[%0d]: got %0d expected %0d", n, z_got[n], zref[n]);
         end
      end
   endtask

   task automatic test_zero();
      run_seq("zero_0x4", 0, 4, 1'b0, -1);
      run_seq("zero_5x0", 5, 0, 1'b0, -1);
      run_seq("zero_0x0", 0, 0, 1'b0, -1);
   endtask

   task automatic test_max();
      fill_random(15);
      run_seq("max_32x32", 32, 32, 1'b0, -1);
   endtask

   task automatic test_reset_mid();
      int idx = -1;
      fill_random(15);
      build_exp(3, 2);
      for (int i = 0; i < exp_q.size(); i++)
         if (idx < 0 && exp_q[i].xrd && (int'(exp_q[i].xa) + int'(exp_q[i].ya) == 2))
            idx = i;
      run_seq("reset_mid", 3, 2, 1'b0, idx);
      run_seq("after_reset_3x2", 3, 2, 1'b0, -1);
   endtask

   task automatic test_ignore_start();
      fill_random(15);
      run_seq("ignore_start_4x3", 4, 3, 1'b1, -1);
      run_seq("ignore_start_2x5", 2, 5, 1'b1, -1);
   endtask

   task automatic test_back_to_back();
      fill_random(15);
      run_seq("b2b_a", 2, 3, 1'b0, -1);
      run_seq("b2b_b", 1, 4, 1'b0, -1);
      run_seq("b2b_c", 0, 2, 1'b0, -1);
      run_seq("b2b_d", 3, 3, 1'b0, -1);
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         fill_random(255);
         run_seq("random", int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), 1'b0, -1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_max();
      test_reset_mid();
      test_ignore_start();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
